instruction_fetch: RTL and testbench

- IF stage of the in-order RV32I pipeline, directly upstream of instruction_decoder.
- Keeps the PC, issues word fetches to instruction memory over a valid/ready request channel, and buffers returned words in an in-order fetch queue.
- Presents instruction, PC and the opcode/funct3/funct7 fields to ID with a valid/ready handshake.
- Handles redirects (branch/jump/trap) from EX by flushing and discarding stale in-flight responses.

---
 rtl/instruction_fetch.sv | 132 +++++++++++++
 tb/tb_instruction_fetch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, issues word fetches under a credit limit and
// buffers returned words in an in-order queue that feeds ID.
module instruction_fetch #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            reset_n,   // active-high despite the name
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            imem_rsp_err,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            id_ready,
   output logic            if_valid,
   output logic [31:0]     if_instr,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_pc_plus4,
   output logic [6:0]      if_opcode,
   output logic [2:0]      if_funct3,
   output logic [6:0]      if_funct7,
   output logic            if_fault
);

   localparam int          AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int          CW  = $clog2(DEPTH + 1);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic {S_RUN, S_HALT} state_t;

   state_t          r_state;
   logic [XLEN-1:0] r_pc;
   logic [CW-1:0]   r_outst;
   logic [CW-1:0]   r_disc;
   logic [CW-1:0]   r_cnt;
   logic [AW-1:0]   r_qhd, r_qtl;
   logic [AW-1:0]   r_pf_hd, r_pf_tl;
   logic [31:0]     r_q_instr [DEPTH];
   logic [XLEN-1:0] r_q_pc    [DEPTH];
   logic            r_q_flt   [DEPTH];
   logic [XLEN-1:0] r_pf      [DEPTH];

   logic            w_if_valid, w_pop, w_credit, w_aligned, w_run;
   logic            w_req_valid, w_acc, w_misal, w_rsp, w_keep, w_push;
   logic [CW:0]     w_used;
   logic [CW-1:0]   w_outst_nxt;
   logic [31:0]     w_push_instr;
   logic [XLEN-1:0] w_push_pc;
   logic            w_push_flt;

   // Credits cover both in-flight requests and queued entries, so a
   // response can always be enqueued without back-pressure.
   assign w_if_valid  = (r_cnt != '0) && !reset_n;
   assign w_pop       = w_if_valid && id_ready;
   assign w_used      = (CW+1)'(r_outst) + (CW+1)'(r_cnt) - (CW+1)'(w_pop);
   assign w_credit    = w_used < (CW+1)'(DEPTH);
   assign w_aligned   = (r_pc[1:0] == 2'b00);
   assign w_run       = !reset_n && (r_state == S_RUN) && !redirect_valid;
   assign w_req_valid = w_run && w_aligned && w_credit;
   assign w_acc       = w_req_valid && imem_req_ready;
   assign w_misal     = w_run && !w_aligned && (r_outst == '0) && w_credit;
   assign w_rsp       = imem_rsp_valid && (r_outst != '0);
   assign w_keep      = w_rsp && (r_disc == '0);
   assign w_outst_nxt = r_outst + CW'(w_acc) - CW'(w_rsp);
   assign w_push      = (w_keep || w_misal) && !redirect_valid;

   assign w_push_flt   = w_misal || imem_rsp_err;
   assign w_push_instr = w_push_flt ? NOP : imem_rsp_data;
   assign w_push_pc    = w_misal ? r_pc : r_pf[r_pf_hd];

   always_ff @(posedge clk) begin
      if (reset_n) begin
         r_state <= S_RUN;
         r_pc    <= RESET_PC;
         r_outst <= '0;
         r_disc  <= '0;
         r_cnt   <= '0;
         r_qhd   <= '0;
         r_qtl   <= '0;
         r_pf_hd <= '0;
         r_pf_tl <= '0;
      end else begin
         r_outst <= w_outst_nxt;
         if (w_acc) r_pf_tl <= r_pf_tl + AW'(1);
         if (w_rsp) r_pf_hd <= r_pf_hd + AW'(1);
         if (redirect_valid) begin
            r_pc    <= redirect_pc;
            r_state <= S_RUN;
            r_disc  <= w_outst_nxt;
            r_cnt   <= '0;
            r_qhd   <= '0;
            r_qtl   <= '0;
         end else begin
            if (w_acc) r_pc <= r_pc + XLEN'(4);
            if (w_rsp && (r_disc != '0)) r_disc <= r_disc - CW'(1);
            if (w_push) r_qtl <= r_qtl + AW'(1);
            if (w_pop)  r_qhd <= r_qhd + AW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            // A fault stops fetching; whatever is still in flight is dropped.
            if (w_push && w_push_flt) begin
               r_state <= S_HALT;
               r_disc  <= w_outst_nxt;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_acc) r_pf[r_pf_tl] <= r_pc;
      if (w_push) begin
         r_q_instr[r_qtl] <= w_push_instr;
         r_q_pc[r_qtl]    <= w_push_pc;
         r_q_flt[r_qtl]   <= w_push_flt;
      end
   end

   assign imem_req_valid = w_req_valid;
   assign imem_req_addr  = r_pc;
   assign if_valid       = w_if_valid;
   assign if_instr       = r_q_instr[r_qhd];
   assign if_pc          = r_q_pc[r_qhd];
   assign if_pc_plus4    = if_pc + XLEN'(4);
   assign if_opcode      = if_instr[6:0];
   assign if_funct3      = if_instr[14:12];
   assign if_funct7      = if_instr[31:25];
   assign if_fault       = w_if_valid && r_q_flt[r_qhd];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a fixed-latency memory model.
module tb_instruction_fetch;

   logic        clk, reset_n;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid, imem_rsp_err;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        if_valid, if_fault;
   logic [31:0] if_instr, if_pc, if_pc_plus4;
   logic [6:0]  if_opcode, if_funct7;
   logic [2:0]  if_funct3;

   instruction_fetch #(.XLEN(32), .RESET_PC(32'h100), .DEPTH(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .imem_rsp_err(imem_rsp_err),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_ready(id_ready),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .if_pc_plus4(if_pc_plus4), .if_opcode(if_opcode), .if_funct3(if_funct3),
      .if_funct7(if_funct7), .if_fault(if_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_chk = 0, n_pass = 0;
   int          cyc_n, lat;
   logic        t_rst, t_idr, t_rv;
   logic [31:0] t_rpc, err_addr;
   logic [31:0] mq_addr[$];
   int          mq_due[$];
   logic [31:0] acc_addr[$];
   logic [31:0] dv_pc[$], dv_instr[$];
   logic        dv_flt[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
      else n_pass++;
   endtask

   function automatic logic [31:0] memword(input logic [31:0] a);
      return 32'h0050_0093 | {a[7:0], 24'h0};
   endfunction

   // One clock: apply this cycle's inputs after the edge, then observe.
   task automatic step();
      logic [31:0] a;
      int          d;
      @(posedge clk);
      #2;
      cyc_n++;
      reset_n        = t_rst;
      id_ready       = t_idr;
      redirect_valid = t_rv;
      redirect_pc    = t_rpc;
      imem_rsp_valid = 1'b0;
      imem_rsp_err   = 1'b0;
      imem_rsp_data  = 32'h0;
      if (mq_addr.size() > 0 && mq_due[0] == cyc_n) begin
         a = mq_addr.pop_front();
         d = mq_due.pop_front();
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = memword(a);
         imem_rsp_err   = (a == err_addr);
      end
      #2;
      if (imem_req_valid && imem_req_ready) begin
         mq_addr.push_back(imem_req_addr);
         mq_due.push_back(cyc_n + lat);
         acc_addr.push_back(imem_req_addr);
      end
      if (if_valid && id_ready) begin
         dv_pc.push_back(if_pc);
         dv_instr.push_back(if_instr);
         dv_flt.push_back(if_fault);
      end
   endtask

   // Leaves the bench in cycle 0, the first cycle out of reset.
   task automatic do_reset(input int l, input logic [31:0] ea);
      t_rst = 1'b1; t_idr = 1'b1; t_rv = 1'b0; t_rpc = 32'h0;
      lat = l; err_addr = ea;
      mq_addr.delete(); mq_due.delete();
      step(); step();
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_if_valid", if_valid, 0);
      chk("rst_if_fault", if_fault, 0);
      acc_addr.delete(); dv_pc.delete(); dv_instr.delete(); dv_flt.delete();
      t_rst = 1'b0;
      cyc_n = -1;
      step();
   endtask

   initial begin
      reset_n = 1'b1; imem_req_ready = 1'b1; id_ready = 1'b1;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; imem_rsp_err = 1'b0;
      cyc_n = 0; lat = 1;

      // Streaming from reset, 1-cycle memory
      do_reset(1, 32'h1);
      chk("t1_c0_req", imem_req_valid, 1);
      chk("t1_c0_addr", imem_req_addr, 32'h100);
      step();
      chk("t1_c1_addr", imem_req_addr, 32'h104);
      chk("t1_c1_ifv", if_valid, 0);
      step();
      chk("t1_c2_addr", imem_req_addr, 32'h108);
      chk("t1_c2_ifv", if_valid, 1);
      chk("t1_c2_pc", if_pc, 32'h100);
      chk("t1_c2_instr", if_instr, 32'h0050_0093);
      chk("t1_c2_opc", if_opcode, 7'h13);
      chk("t1_c2_f3", if_funct3, 3'h0);
      chk("t1_c2_pc4", if_pc_plus4, 32'h104);
      step();
      chk("t1_c3_pc", if_pc, 32'h104);
      chk("t1_c3_f7", if_funct7, 7'h02);

      // ID stall for 5 cycles starting at the first valid
      do_reset(1, 32'h1);
      step();
      t_idr = 1'b0;
      for (int k = 2; k <= 6; k++) begin
         step();
         chk("t2_stall_req", imem_req_valid, 0);
         chk("t2_stall_head", if_pc, 32'h100);
      end
      chk("t2_acc_cnt", acc_addr.size(), 2);
      t_idr = 1'b1;
      repeat (4) step();
      chk("t2_dv_n", dv_pc.size(), 4);
      chk("t2_dv0", dv_pc[0], 32'h100);
      chk("t2_dv1", dv_pc[1], 32'h104);
      chk("t2_dv2", dv_pc[2], 32'h108);
      chk("t2_dv3", dv_pc[3], 32'h10c);

      // Redirect with two requests in flight, 3-cycle memory
      do_reset(3, 32'h1);
      step();
      t_rv = 1'b1; t_rpc = 32'h200;
      step();
      chk("t3_redir_req", imem_req_valid, 0);
      t_rv = 1'b0;
      step();
      chk("t3_c3_ifv", if_valid, 0);
      chk("t3_c3_req", imem_req_valid, 0);
      step();
      chk("t3_c4_req", imem_req_valid, 1);
      chk("t3_c4_addr", imem_req_addr, 32'h200);
      repeat (4) step();
      chk("t3_c8_ifv", if_valid, 1);
      chk("t3_c8_pc", if_pc, 32'h200);
      step();
      chk("t3_dv_n", dv_pc.size(), 2);
      chk("t3_dv0", dv_pc[0], 32'h200);
      chk("t3_dv1", dv_pc[1], 32'h204);

      // Redirect to a misaligned target, then recover
      do_reset(1, 32'h1);
      repeat (3) step();
      t_rv = 1'b1; t_rpc = 32'h302;
      step();
      chk("t4_redir_req", imem_req_valid, 0);
      chk("t4_redir_pop", if_pc, 32'h108);
      t_rv = 1'b0;
      step();
      chk("t4_c5_req", imem_req_valid, 0);
      chk("t4_c5_ifv", if_valid, 0);
      step();
      chk("t4_flt_v", if_valid, 1);
      chk("t4_flt", if_fault, 1);
      chk("t4_flt_pc", if_pc, 32'h302);
      chk("t4_flt_instr", if_instr, 32'h13);
      for (int k = 7; k <= 10; k++) begin
         step();
         chk("t4_halt_req", imem_req_valid, 0);
         chk("t4_halt_ifv", if_valid, 0);
      end
      chk("t4_dv_n", dv_pc.size(), 4);
      chk("t4_dv3", dv_pc[3], 32'h302);
      chk("t4_dv3_flt", dv_flt[3], 1);
      t_rv = 1'b1; t_rpc = 32'h400;
      step();
      t_rv = 1'b0;
      step();
      chk("t4_resume_req", imem_req_valid, 1);
      chk("t4_resume_addr", imem_req_addr, 32'h400);
      step(); step();
      chk("t4_resume_pc", if_pc, 32'h400);

      // Access fault on the response for 0x104
      do_reset(1, 32'h104);
      repeat (3) step();
      chk("t5_ifv", if_valid, 1);
      chk("t5_pc", if_pc, 32'h104);
      chk("t5_flt", if_fault, 1);
      chk("t5_instr", if_instr, 32'h13);
      chk("t5_req", imem_req_valid, 0);
      for (int k = 4; k <= 7; k++) begin
         step();
         chk("t5_halt_req", imem_req_valid, 0);
         chk("t5_halt_ifv", if_valid, 0);
      end
      chk("t5_acc_n", acc_addr.size(), 3);
      chk("t5_dv_n", dv_pc.size(), 2);
      chk("t5_dv0", dv_pc[0], 32'h100);
      chk("t5_dv0_flt", dv_flt[0], 0);
      chk("t5_dv0_instr", dv_instr[0], 32'h0050_0093);

      // Redirect in the same cycle as a response, one more in flight
      do_reset(2, 32'h1);
      step();
      t_rv = 1'b1; t_rpc = 32'h600;
      step();
      chk("t6_redir_req", imem_req_valid, 0);
      t_rv = 1'b0;
      for (int k = 3; k <= 9; k++) begin
         step();
         chk("t6_credit", (mq_addr.size() <= 2) ? 1 : 0, 1);
      end
      chk("t6_dv_n", dv_pc.size(), 3);
      chk("t6_dv0", dv_pc[0], 32'h600);
      chk("t6_dv1", dv_pc[1], 32'h604);
      chk("t6_dv2", dv_pc[2], 32'h608);

      // PC wrap at the top of the address space
      do_reset(1, 32'h1);
      t_rv = 1'b1; t_rpc = 32'hFFFF_FFFC;
      step();
      t_rv = 1'b0;
      step();
      chk("t7_addr_top", imem_req_addr, 32'hFFFF_FFFC);
      chk("t7_req_top", imem_req_valid, 1);
      step();
      chk("t7_addr_wrap", imem_req_addr, 32'h0);
      step();
      chk("t7_pc", if_pc, 32'hFFFF_FFFC);
      chk("t7_pc4", if_pc_plus4, 32'h0);
      chk("t7_f7", if_funct7, 7'h7E);
      chk("t7_dv_n", dv_pc.size(), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
